fpu_seq: RTL

FPU_SEQ -- requirements
Module: fpu_seq

---
 rtl/fpu_seq_pkg.sv | 58 +++++
 rtl/fpu_seq_if.sv | 25 ++
 rtl/fpu_lat_rom.sv | 51 +++++
 rtl/fpu_seq.sv | 117 +++++++++++
 4 files changed

// File: rtl/fpu_seq_pkg.sv
// Shared types and constants for the FPU sequencer: state encoding, opcode map,
// result-mux selects, unit latencies and the divider timeout.
package fpu_seq_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 5;

    // The divider is abandoned this many cycles after acceptance
    localparam int unsigned TIMEOUT_CYC = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [OP_W-1:0] OP_FADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_FSUB   = 4'd1;
    localparam logic [OP_W-1:0] OP_FMUL   = 4'd2;
    localparam logic [OP_W-1:0] OP_FDIV   = 4'd3;
    localparam logic [OP_W-1:0] OP_FSQRT  = 4'd4;
    localparam logic [OP_W-1:0] OP_FSGNJ  = 4'd5;
    localparam logic [OP_W-1:0] OP_FSGNJN = 4'd6;
    localparam logic [OP_W-1:0] OP_FSGNJX = 4'd7;
    localparam logic [OP_W-1:0] OP_FEQ    = 4'd8;
    localparam logic [OP_W-1:0] OP_FLT    = 4'd9;
    localparam logic [OP_W-1:0] OP_FLE    = 4'd10;
    localparam logic [OP_W-1:0] OP_FCVTSW = 4'd11;
    localparam logic [OP_W-1:0] OP_FCVTWS = 4'd12;
    localparam logic [OP_W-1:0] OP_FMV    = 4'd13;

    localparam logic [SEL_W-1:0] SEL_ADD  = 3'd0;
    localparam logic [SEL_W-1:0] SEL_MUL  = 3'd1;
    localparam logic [SEL_W-1:0] SEL_DIV  = 3'd2;
    localparam logic [SEL_W-1:0] SEL_SQRT = 3'd3;
    localparam logic [SEL_W-1:0] SEL_SGNJ = 3'd4;
    localparam logic [SEL_W-1:0] SEL_CMP  = 3'd5;
    localparam logic [SEL_W-1:0] SEL_CVT  = 3'd6;
    localparam logic [SEL_W-1:0] SEL_MV   = 3'd7;

    localparam logic [CNT_W-1:0] LAT_ADD  = 5'd3;
    localparam logic [CNT_W-1:0] LAT_MUL  = 5'd2;
    localparam logic [CNT_W-1:0] LAT_SQRT = 5'd6;
    localparam logic [CNT_W-1:0] LAT_SGNJ = 5'd1;
    localparam logic [CNT_W-1:0] LAT_CMP  = 5'd1;
    localparam logic [CNT_W-1:0] LAT_CVT  = 5'd2;
    localparam logic [CNT_W-1:0] LAT_MV   = 5'd1;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [CNT_W-1:0] lat;
        logic             variable_lat;
        logic             illegal;
    } lat_entry_t;

endpackage

// File: rtl/fpu_seq_if.sv
// Decoder-side handshake between the floating-point decoder and the FPU sequencer.
interface fpu_seq_if;
    import fpu_seq_pkg::*;

    logic             fpu_go;
    logic [OP_W-1:0]  fpucontrol;
    logic             fdiv_done;
    logic             unit_start;
    logic [SEL_W-1:0] unit_sel;
    logic             res_we;
    logic             fpu_valid;
    logic             fpu_busy;
    logic             illegal;

    modport master (
        output fpu_go, fpucontrol, fdiv_done,
        input  unit_start, unit_sel, res_we, fpu_valid, fpu_busy, illegal
    );

    modport slave (
        input  fpu_go, fpucontrol, fdiv_done,
        output unit_start, unit_sel, res_we, fpu_valid, fpu_busy, illegal
    );

endinterface

// File: rtl/fpu_lat_rom.sv
// Opcode lookup: result-mux select, fixed latency, variable-latency and illegal flags.
// Purely combinational so the decoder can share it.
module fpu_lat_rom
    import fpu_seq_pkg::*;
(
    input  logic [OP_W-1:0] i_op,
    output lat_entry_t      o_entry
);

    always_comb begin
        o_entry = '{sel: SEL_ADD, lat: CNT_W'(1), variable_lat: 1'b0, illegal: 1'b0};
        case (i_op)
            OP_FADD, OP_FSUB: begin
                o_entry.sel = SEL_ADD;
                o_entry.lat = LAT_ADD;
            end
            OP_FMUL: begin
                o_entry.sel = SEL_MUL;
                o_entry.lat = LAT_MUL;
            end
            OP_FDIV: begin
                o_entry.sel          = SEL_DIV;
                o_entry.variable_lat = 1'b1;
            end
            OP_FSQRT: begin
                o_entry.sel = SEL_SQRT;
                o_entry.lat = LAT_SQRT;
            end
            OP_FSGNJ, OP_FSGNJN, OP_FSGNJX: begin
                o_entry.sel = SEL_SGNJ;
                o_entry.lat = LAT_SGNJ;
            end
            OP_FEQ, OP_FLT, OP_FLE: begin
                o_entry.sel = SEL_CMP;
                o_entry.lat = LAT_CMP;
            end
            OP_FCVTSW, OP_FCVTWS: begin
                o_entry.sel = SEL_CVT;
                o_entry.lat = LAT_CVT;
            end
            OP_FMV: begin
                o_entry.sel = SEL_MV;
                o_entry.lat = LAT_MV;
            end
            default: begin
                o_entry.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fpu_seq.sv
// FPU sequencer: accepts one decoder request at a time, starts the selected unit and
// times its completion from a fixed latency or from the divider's done pulse.
module fpu_seq
    import fpu_seq_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    fpu_seq_if.slave bus
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [OP_W-1:0]  r_op;
    logic [SEL_W-1:0] r_sel;
    logic             r_valid;
    logic             r_res_we;
    logic             r_busy;
    logic             r_illegal;

    lat_entry_t       w_ent;
    logic             w_accept;
    logic             w_is_div;
    logic             w_last;
    logic             w_run_fin;
    logic             w_timeout;

    fpu_lat_rom u_lat_rom (
        .i_op    (bus.fpucontrol),
        .o_entry (w_ent)
    );

    assign w_accept = (r_state == ST_IDLE) && bus.fpu_go && !rst;
    assign w_is_div = (r_op == OP_FDIV);
    assign w_last   = (r_cnt <= CNT_W'(1));

    // A divide finishes on its done pulse or when the timeout counter runs out
    assign w_run_fin = w_is_div ? (bus.fdiv_done || w_last) : w_last;
    assign w_timeout = w_is_div && !bus.fdiv_done && w_last;

    assign bus.unit_start = w_accept && !w_ent.illegal;
    assign bus.unit_sel   = r_sel;
    assign bus.res_we     = r_res_we;
    assign bus.fpu_valid  = r_valid;
    assign bus.fpu_busy   = r_busy;
    assign bus.illegal    = r_illegal;

    // The completion pulse is the first cycle of DONE, so DONE is always entered with r_valid set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_sel     <= '0;
            r_valid   <= 1'b0;
            r_res_we  <= 1'b0;
            r_busy    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_res_we <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.fpu_go) begin
                        r_op   <= bus.fpucontrol;
                        r_sel  <= w_ent.sel;
                        r_busy <= 1'b1;
                        if (w_ent.illegal) begin
                            r_state   <= ST_DONE;
                            r_cnt     <= '0;
                            r_valid   <= 1'b1;
                            r_illegal <= 1'b1;
                        end else if (w_ent.variable_lat) begin
                            r_state <= ST_RUN;
                            r_cnt   <= CNT_W'(TIMEOUT_CYC - 1);
                        end else if (w_ent.lat <= CNT_W'(1)) begin
                            r_state  <= ST_DONE;
                            r_cnt    <= '0;
                            r_valid  <= 1'b1;
                            r_res_we <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_cnt   <= w_ent.lat - CNT_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                    if (w_run_fin) begin
                        r_state  <= ST_DONE;
                        r_valid  <= 1'b1;
                        r_res_we <= 1'b1;
                        if (w_timeout) begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= bus.fpu_go ? ST_DRAIN : ST_IDLE;
                    r_busy  <= bus.fpu_go;
                end
                ST_DRAIN: begin
                    if (!bus.fpu_go) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
